// File: rtl/jzjpcc_decode_ct.sv
// rtl/jzjpcc_decode_ct.sv - decode-stage control-transfer resolution and hazard stall unit
//
// Purpose: resolves JAL, JALR and conditional branches in decode. Drives the
//          PC redirect, fetch/decode stalls and decode/execute flushes that
//          fetch obeys on the next posedge. Stalls on register-operand hazards
//          that the in-decode branch comparison cannot forward around.
// Optional feature: define JZJPCC_CT_STATS_EN to add ctTakenCount/ctStallCount.
// Ports:
//   clock, reset                      sole clock, synchronous active-high reset
//   instruction_decode                decode-slot instruction, byte-swapped (big endian)
//   currentPC_decode                  word address of the decode-slot instruction
//   rs1Data_decode, rs2Data_decode    forwarded register operands
//   rdExecute, regWriteExecute        execute-stage destination and write enable
//   rdMemory, memReadMemory           memory-stage destination and load flag
//   pcCTWriteEnable                   fetch latches controlTransferNewPC
//   controlTransferNewPC              redirect target word address
//   linkPC_decode                     currentPC_decode + 1 (return address)
//   stall_fetch, stall_decode         hold fetch PC / decode registers
//   flush_execute, flush_decode       inject bubble into execute / decode
//   ctMisaligned                      sticky: taken transfer with target bit 1 set
//   ctTakenCount, ctStallCount        (JZJPCC_CT_STATS_EN only) event counters

module jzjpcc_decode_ct (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction_decode,
    input  logic [31:2] currentPC_decode,
    input  logic [31:0] rs1Data_decode,
    input  logic [31:0] rs2Data_decode,
    input  logic [4:0]  rdExecute,
    input  logic        regWriteExecute,
    input  logic [4:0]  rdMemory,
    input  logic        memReadMemory,
    output logic        pcCTWriteEnable,
    output logic [31:2] controlTransferNewPC,
    output logic [31:2] linkPC_decode,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        flush_execute,
    output logic        flush_decode,
    output logic        ctMisaligned
`ifdef JZJPCC_CT_STATS_EN
    ,
    output logic [31:0] ctTakenCount,
    output logic [31:0] ctStallCount
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ct_misaligned_q, ct_misaligned_d;

    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx, rs2_idx;
    logic        is_jal, is_jalr, is_branch;
    logic [31:0] imm_i, imm_b, imm_j;
    logic [31:0] pc_byte;
    logic [31:0] target;
    logic        branch_cond;
    logic        taken;
    logic        rs1_conflict, rs2_conflict, hazard;

    // A register conflicts when a not-yet-available producer targets it;
    // x0 never conflicts since it is hardwired.
    function automatic logic reg_conflict(input logic [4:0] idx,
                                          input logic [4:0] rd_ex, input logic we_ex,
                                          input logic [4:0] rd_mem, input logic ld_mem);
        return (idx != 5'd0) && ((we_ex && (idx == rd_ex)) || (ld_mem && (idx == rd_mem)));
    endfunction

    // Decode and target computation
    always_comb begin
        insn      = {instruction_decode[7:0], instruction_decode[15:8],
                     instruction_decode[23:16], instruction_decode[31:24]};
        opcode    = insn[6:0];
        funct3    = insn[14:12];
        rs1_idx   = insn[19:15];
        rs2_idx   = insn[24:20];
        is_jal    = (opcode == 7'b1101111);
        is_jalr   = (opcode == 7'b1100111) && (funct3 == 3'b000);
        is_branch = (opcode == 7'b1100011);

        imm_i = {{20{insn[31]}}, insn[31:20]};
        imm_b = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        imm_j = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};

        pc_byte = {currentPC_decode, 2'b00};

        branch_cond = 1'b0;
        case (funct3)
            3'b000:  branch_cond = (rs1Data_decode == rs2Data_decode);
            3'b001:  branch_cond = (rs1Data_decode != rs2Data_decode);
            3'b100:  branch_cond = ($signed(rs1Data_decode) <  $signed(rs2Data_decode));
            3'b101:  branch_cond = ($signed(rs1Data_decode) >= $signed(rs2Data_decode));
            3'b110:  branch_cond = (rs1Data_decode <  rs2Data_decode);
            3'b111:  branch_cond = (rs1Data_decode >= rs2Data_decode);
            default: branch_cond = 1'b0;
        endcase

        if (is_jalr) begin
            target = (rs1Data_decode + imm_i) & 32'hFFFF_FFFE;
        end else if (is_jal) begin
            target = pc_byte + imm_j;
        end else begin
            target = pc_byte + imm_b;
        end

        taken = is_jal || is_jalr || (is_branch && branch_cond);

        rs1_conflict = (is_branch || is_jalr) &&
                       reg_conflict(rs1_idx, rdExecute, regWriteExecute, rdMemory, memReadMemory);
        rs2_conflict = is_branch &&
                       reg_conflict(rs2_idx, rdExecute, regWriteExecute, rdMemory, memReadMemory);
        hazard       = rs1_conflict || rs2_conflict;
    end

    // Control outputs and next state; priority reset > hazard > redirect > misaligned
    always_comb begin
        pcCTWriteEnable      = 1'b0;
        stall_fetch          = 1'b0;
        stall_decode         = 1'b0;
        flush_execute        = 1'b0;
        flush_decode         = 1'b0;
        controlTransferNewPC = reset ? 30'd0 : target[31:2];
        linkPC_decode        = currentPC_decode + 30'd1;
        state_d              = ST_RUN;
        ct_misaligned_d      = ct_misaligned_q;

        if (reset) begin
            ct_misaligned_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (hazard) begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                flush_execute = 1'b1;
            end else if (taken && !target[1]) begin
                pcCTWriteEnable = 1'b1;
                flush_decode    = 1'b1;
                state_d         = ST_SHADOW;
            end else if (taken) begin
                ct_misaligned_d = 1'b1;
            end
        end
        // ST_SHADOW: slot holds the flushed bubble, everything stays quiet.
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_RUN;
            ct_misaligned_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ct_misaligned_q <= ct_misaligned_d;
        end
    end

    assign ctMisaligned = ct_misaligned_q;

`ifdef JZJPCC_CT_STATS_EN
    logic [31:0] taken_count_q, taken_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        taken_count_d = taken_count_q + {31'd0, pcCTWriteEnable};
        stall_count_d = stall_count_q + {31'd0, stall_fetch};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            taken_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            taken_count_q <= taken_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ctTakenCount = taken_count_q;
    assign ctStallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_jzjpcc_decode_ct.sv
// tb/tb_jzjpcc_decode_ct.sv - self-checking bench for jzjpcc_decode_ct

module tb_jzjpcc_decode_ct;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic [29:0] pc;
    logic [31:0] rs1d, rs2d;
    logic [4:0]  rd_ex, rd_mem;
    logic        rw_ex, mr_mem;

    logic        pc_we;
    logic [29:0] new_pc, link_pc;
    logic        st_f, st_d, fl_ex, fl_d, mis;
`ifdef JZJPCC_CT_STATS_EN
    logic [31:0] taken_cnt, stall_cnt;
`endif

    jzjpcc_decode_ct dut (
        .clock                (clock),
        .reset                (reset),
        .instruction_decode   (instr),
        .currentPC_decode     (pc),
        .rs1Data_decode       (rs1d),
        .rs2Data_decode       (rs2d),
        .rdExecute            (rd_ex),
        .regWriteExecute      (rw_ex),
        .rdMemory             (rd_mem),
        .memReadMemory        (mr_mem),
        .pcCTWriteEnable      (pc_we),
        .controlTransferNewPC (new_pc),
        .linkPC_decode        (link_pc),
        .stall_fetch          (st_f),
        .stall_decode         (st_d),
        .flush_execute        (fl_ex),
        .flush_decode         (fl_d),
        .ctMisaligned         (mis)
`ifdef JZJPCC_CT_STATS_EN
        ,
        .ctTakenCount         (taken_cnt),
        .ctStallCount         (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Semantic description of the slot, kept alongside the encoded word
    localparam int K_OTHER = 0, K_JAL = 1, K_JALR = 2, K_BRANCH = 3;
    int          m_kind;
    logic [4:0]  m_rs1, m_rs2;
    logic [2:0]  m_f3;
    logic [31:0] m_imm;

    // Reference model state
    bit          m_shadow = 0;
    bit          m_mis = 0;
    logic [31:0] m_taken = 0;
    logic [31:0] m_stall = 0;

    // Per-cycle expectations
    bit          e_we, e_stall, e_fld, e_taken, e_hazard;
    logic [31:0] e_target;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // kind: instruction class; for JALR a nonzero f3 is encoded but is a non-CT op
    task automatic set_insn(input int kind, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [2:0] f3, input logic [31:0] imm);
        logic [31:0] raw;
        case (kind)
            K_JAL:    raw = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
            K_JALR:   raw = {imm[11:0], r1, f3, 5'd1, 7'b1100111};
            K_BRANCH: raw = {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
            default:  raw = {imm[11:0], r1, f3, 5'd3, 7'b0010011};
        endcase
        instr  = bswap(raw);
        m_kind = (kind == K_JALR && f3 != 3'b000) ? K_OTHER : kind;
        m_rs1  = r1;
        m_rs2  = r2;
        m_f3   = f3;
        m_imm  = imm;
    endtask

    task automatic set_nop();
        set_insn(K_OTHER, 5'd0, 5'd0, 3'd0, 32'd0);
        instr = 32'h1300_0000;
    endtask

    task automatic clr_haz();
        rd_ex = 0; rw_ex = 0; rd_mem = 0; mr_mem = 0;
    endtask

    function automatic bit blocked(input logic [4:0] r);
        return (r != 0) && ((rw_ex && r == rd_ex) || (mr_mem && r == rd_mem));
    endfunction

    // Compute expectations from current inputs, then check outputs at negedge
    task automatic eval_and_check();
        bit cond;
        e_taken = 0; e_target = 0; e_hazard = 0;
        case (m_kind)
            K_JAL: begin
                e_taken  = 1;
                e_target = {pc, 2'b00} + m_imm;
            end
            K_JALR: begin
                e_taken  = 1;
                e_target = (rs1d + m_imm) & ~32'd1;
                e_hazard = blocked(m_rs1);
            end
            K_BRANCH: begin
                case (m_f3)
                    3'd0: cond = (rs1d == rs2d);
                    3'd1: cond = (rs1d != rs2d);
                    3'd4: cond = ($signed(rs1d) <  $signed(rs2d));
                    3'd5: cond = ($signed(rs1d) >= $signed(rs2d));
                    3'd6: cond = (rs1d <  rs2d);
                    3'd7: cond = (rs1d >= rs2d);
                    default: cond = 0;
                endcase
                e_taken  = cond;
                e_target = {pc, 2'b00} + m_imm;
                e_hazard = blocked(m_rs1) || blocked(m_rs2);
            end
            default: ;
        endcase

        e_we = 0; e_stall = 0; e_fld = 0;
        if (!reset && !m_shadow) begin
            if (e_hazard)                    e_stall = 1;
            else if (e_taken && !e_target[1]) begin e_we = 1; e_fld = 1; end
        end

        @(negedge clock);
        check_eq("pc_we", pc_we, e_we);
        check_eq("stall_fetch", st_f, e_stall);
        check_eq("stall_decode", st_d, e_stall);
        check_eq("flush_execute", fl_ex, e_stall);
        check_eq("flush_decode", fl_d, e_fld);
        check_eq("link_pc", link_pc, pc + 30'd1);
        if (reset) check_eq("new_pc_reset", new_pc, 32'd0);
        else if (e_we) check_eq("new_pc", new_pc, e_target[31:2]);
    endtask

    // Clock edge: advance the model and check registered state
    task automatic advance();
        if (reset) begin
            m_shadow = 0; m_mis = 0; m_taken = 0; m_stall = 0;
        end else begin
            if (!m_shadow && !e_hazard && e_taken && e_target[1]) m_mis = 1;
            m_taken  = m_taken + e_we;
            m_stall  = m_stall + e_stall;
            m_shadow = e_we;
        end
        @(posedge clock);
        #1;
        check_eq("ct_misaligned", mis, m_mis);
`ifdef JZJPCC_CT_STATS_EN
        check_eq("taken_count", taken_cnt, m_taken);
        check_eq("stall_count", stall_cnt, m_stall);
`endif
    endtask

    task automatic step();
        eval_and_check();
        advance();
    endtask

    initial begin
        reset = 1; pc = 30'h40; rs1d = 0; rs2d = 0;
        clr_haz();
        set_nop();
        @(posedge clock);
        #1;
        step();
        step();

        // Released with a nop: everything quiet
        reset = 0;
        eval_and_check();
        check_eq("rst_we", pc_we, 0);
        check_eq("rst_stall", st_f, 0);
        advance();
        check_eq("rst_mis", mis, 0);

        // JAL x1,+8 at PC 0x100
        pc = 30'h40;
        set_insn(K_JAL, 0, 0, 0, 32'd8);
        eval_and_check();
        check_eq("jal_we", pc_we, 1);
        check_eq("jal_fld", fl_d, 1);
        check_eq("jal_newpc", new_pc, 30'h42);
        check_eq("jal_link", link_pc, 30'h41);
        advance();
        // Shadow cycle, even with a JAL in the slot
        eval_and_check();
        check_eq("shadow_we", pc_we, 0);
        check_eq("shadow_fld", fl_d, 0);
        advance();

        // Signed vs unsigned compares, BEQ unequal
        rs1d = 32'hFFFF_FFFF; rs2d = 32'd1;
        set_insn(K_BRANCH, 5'd1, 5'd2, 3'b100, 32'd16);
        eval_and_check();
        check_eq("blt_taken", pc_we, 1);
        advance();
        step();
        set_insn(K_BRANCH, 5'd1, 5'd2, 3'b110, 32'd16);
        eval_and_check();
        check_eq("bltu_not", pc_we, 0);
        advance();
        set_insn(K_BRANCH, 5'd1, 5'd2, 3'b000, 32'd16);
        eval_and_check();
        check_eq("beq_ne", pc_we, 0);
        advance();

        // Load-use on BEQ x5,x6: two stall cycles, then resolves
        rs1d = 32'h55; rs2d = 32'h55;
        set_insn(K_BRANCH, 5'd5, 5'd6, 3'b000, 32'h20);
        rw_ex = 1; rd_ex = 5;
        eval_and_check();
        check_eq("lu_stall1", st_f, 1);
        advance();
        rw_ex = 0; mr_mem = 1; rd_mem = 5;
        eval_and_check();
        check_eq("lu_stall2", st_f, 1);
        advance();
        clr_haz();
        eval_and_check();
        check_eq("lu_resolve", pc_we, 1);
        advance();
        step();
        // Same with rd = 0: no stall
        rs2d = 32'h56;
        rw_ex = 1; rd_ex = 0;
        eval_and_check();
        check_eq("rd0_nostall1", st_f, 0);
        advance();
        rw_ex = 0; mr_mem = 1; rd_mem = 0;
        eval_and_check();
        check_eq("rd0_nostall2", st_f, 0);
        advance();
        clr_haz();

        // JALR with misaligned target: sticky flag, no redirect
        rs1d = 32'h1002;
        set_insn(K_JALR, 5'd7, 5'd0, 3'b000, 32'd0);
        eval_and_check();
        check_eq("jalr_mis_we", pc_we, 0);
        advance();
        check_eq("jalr_mis_flag", mis, 1);
        set_nop();
        step();
        step();
        check_eq("mis_sticky", mis, 1);

        // Reset during SHADOW, then JAL redirects immediately
        set_insn(K_JAL, 0, 0, 0, 32'h100);
        step();
        reset = 1;
        step();
        reset = 0;
        eval_and_check();
        check_eq("post_rst_jal", pc_we, 1);
        advance();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int k;
            logic [31:0] imm;
            reset = ($urandom_range(0, 59) == 0);
            pc    = $urandom;
            rs1d  = $urandom;
            rs2d  = ($urandom_range(0, 3) == 0) ? rs1d : $urandom;
            rd_ex = $urandom_range(0, 7); rw_ex = $urandom_range(0, 1);
            rd_mem = $urandom_range(0, 7); mr_mem = $urandom_range(0, 1);
            k = $urandom_range(0, 3);
            case (k)
                K_JAL:    begin imm = $urandom; imm = {{11{imm[20]}}, imm[20:1], 1'b0}; end
                K_BRANCH: begin imm = $urandom; imm = {{19{imm[12]}}, imm[12:1], 1'b0}; end
                default:  begin imm = $urandom; imm = {{20{imm[11]}}, imm[11:0]}; end
            endcase
            set_insn(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     (k == K_JALR && $urandom_range(0, 3) != 0) ? 3'd0 : 3'($urandom_range(0, 7)),
                     imm);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jzjpcc_decode_ct.md
# jzjpcc_decode_ct

Decode-stage control-transfer and hazard unit for the jzjpcc pipeline. It is the counterpart of the fetch stage. It consumes the fetched instruction and PC latched into decode and resolves JAL, JALR and conditional branches in decode. It drives back the PC redirect, the fetch stall and the decode flush that fetch obeys on the next posedge. It also stalls decode on register-operand hazards that the in-decode branch comparison cannot forward around.

## Interface
Parameters: none.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- instruction_decode  in  32  instruction in the decode slot, big endian (byte-swapped relative to RISC-V encoding).
- currentPC_decode  in  [31:2]  word address of instruction_decode.
- rs1Data_decode, rs2Data_decode  in  32 each  register operands, already forwarded from writeback.
- rdExecute  in  5  destination register of the execute stage.
- regWriteExecute  in  1  execute stage writes rdExecute.
- rdMemory  in  5  destination register of the memory stage.
- memReadMemory  in  1  memory stage is a load.
- pcCTWriteEnable  out  1  fetch latches controlTransferNewPC.
- controlTransferNewPC  out  [31:2]  redirect target word address.
- linkPC_decode  out  [31:2]  currentPC_decode + 1, wraps mod 2^30.
- stall_fetch  out  1  fetch holds its PC.
- stall_decode  out  1  decode registers hold.
- flush_execute  out  1  inject a bubble into execute.
- flush_decode  out  1  decode slot becomes a nop next posedge.
- ctMisaligned  out  1  sticky flag: a taken transfer had target bit 1 set.

## Operation
- Byte-swap first: insn = {i[7:0], i[15:8], i[23:16], i[31:24]}.
- Instruction classes, decoded on insn[6:0]:
  - JAL: opcode 1101111.
  - JALR: opcode 1100111, funct3 000.
  - BRANCH: opcode 1100011.
  - Anything else is a non-CT instruction.
- Targets, computed as full 32-bit sums with the carry discarded:
  - JAL: {PC,00} + immJ.
  - BRANCH: {PC,00} + immB.
  - JALR: (rs1 + immI) & ~1.
- controlTransferNewPC = target[31:2].
- Branch conditions by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. funct3 010/011 is never taken.
- Hazard: the slot holds a BRANCH (uses rs1, rs2) or a JALR (uses rs1), and a used rs is nonzero and matches either:
  - rdExecute with regWriteExecute set, or
  - rdMemory with memReadMemory set.
- FSM with 2 states, RUN and SHADOW. Reset enters RUN.
- RUN:
  - Hazard: stall_fetch = stall_decode = flush_execute = 1; no redirect; stay in RUN.
  - Else, taken CT (JAL, JALR, or branch with condition true) with target[1] = 0: pcCTWriteEnable = 1 and flush_decode = 1; go to SHADOW.
  - Else, taken CT with target[1] = 1: no redirect; set ctMisaligned; the instruction is otherwise treated as a nop; stay in RUN.
  - Else: all control outputs 0.
- SHADOW: the slot holds the flushed bubble. All control outputs are 0 regardless of inputs. Next state is RUN.
- Priority: reset, then hazard stall, then redirect, then misaligned.
- ctMisaligned clears only on reset.

## Timing
- pcCTWriteEnable, controlTransferNewPC, stall_*, flush_* and linkPC_decode are combinational from the current state and inputs, so fetch acts on the next posedge.
- Resolution latency: a taken transfer costs exactly 1 bubble cycle (SHADOW).
- A load-use hazard on a branch operand costs 2 stall cycles: 1 while the load is in execute, 1 while it is in memory.
- An ALU-result hazard costs 1 stall cycle.
- While reset is high, all control outputs are 0 and controlTransferNewPC is 0.
- Reset values: state RUN, ctMisaligned 0.
- Reset asserted while in SHADOW returns the FSM to RUN on that posedge.

## Configuration
- JZJPCC_CT_STATS_EN defined: adds outputs ctTakenCount[31:0] and ctStallCount[31:0].
  - ctTakenCount increments on each cycle with pcCTWriteEnable = 1.
  - ctStallCount increments on each cycle with stall_fetch = 1.
  - Both wrap at 2^32 and reset to 0.
- Macro undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset held for 2 cycles, then released with a nop in decode -> all control outputs 0, ctMisaligned 0, state RUN.
- JAL x1,+8 at PC 0x100 (currentPC_decode = 0x40) -> pcCTWriteEnable = 1, flush_decode = 1, controlTransferNewPC = 0x42, linkPC_decode = 0x41. Next cycle, with any instruction in the slot -> all control outputs 0.
- BLT with rs1 = 0xFFFFFFFF, rs2 = 1 -> taken. Same operands with BLTU -> not taken. BEQ with unequal operands -> pcCTWriteEnable = 0.
- BEQ x5,x6 while memReadMemory = 0 and regWriteExecute = 1 with rdExecute = 5, then next cycle memReadMemory = 1 with rdMemory = 5 -> stall_fetch, stall_decode and flush_execute are 1 for 2 cycles, then the branch resolves. Same sequence with rd = 0 -> no stall.
- JALR with rs1 = 0x1002, imm 0 -> no redirect, ctMisaligned becomes 1 and stays 1 until reset. With JZJPCC_CT_STATS_EN defined, ctTakenCount is unchanged.
- Reset asserted in the SHADOW cycle -> next cycle is RUN, counters are 0, and a JAL in the slot redirects immediately.
